sd_sector_loader: RTL and testbench

//  Sits between the I/O port block and the SD card controller. On a load request
//  it fetches one 512-byte sector, stores it in an internal buffer, then pulses
//  sd_load_valid. The port block then reads the buffer byte by byte through
//  sd_buf_addr and sd_data, which are exposed to the CPU as data port 0x1F0.

---
 rtl/sd_sector_loader_if.sv | 30 +++
 rtl/sd_sector_loader.sv | 121 ++++++++++++
 tb/tb_sd_sector_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_loader_if.sv
// Port-block and card-controller signals of the SD sector loader.
// The loader itself uses the slave modport; its environment uses the master modport.
interface sd_sector_loader_if;
    logic [31:0] sd_sect;
    logic        sd_load_req;
    logic        sd_load_valid;
    logic        sd_load_err;
    logic        sd_busy;
    logic [8:0]  sd_buf_addr;
    logic [7:0]  sd_data;
    logic        card_rd_req;
    logic [31:0] card_rd_addr;
    logic        card_rd_ack;
    logic        card_byte_valid;
    logic [7:0]  card_byte_data;

    modport slave (
        input  sd_sect, sd_load_req, sd_buf_addr,
        input  card_rd_ack, card_byte_valid, card_byte_data,
        output sd_load_valid, sd_load_err, sd_busy, sd_data,
        output card_rd_req, card_rd_addr
    );

    modport master (
        output sd_sect, sd_load_req, sd_buf_addr,
        output card_rd_ack, card_byte_valid, card_byte_data,
        input  sd_load_valid, sd_load_err, sd_busy, sd_data,
        input  card_rd_req, card_rd_addr
    );
endinterface

// File: rtl/sd_sector_loader.sv
// Fetches one 512-byte sector from the SD card controller into a local buffer,
// then lets the port block read it back byte by byte.
module sd_sector_loader #(
    parameter logic [31:0] SECT_OFFSET = 32'h0,
    parameter logic [23:0] TIMEOUT     = 24'hFFFFFF
) (
    input  logic               clk,
    input  logic               reset,
    sd_sector_loader_if.slave  io_sd
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RECV,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [23:0] TIMER_LAST = TIMEOUT - 24'd1;

    state_t      r_state;
    logic [8:0]  r_wr_ptr;
    logic [23:0] r_timer;
    logic        r_load_valid;
    logic        r_load_err;
    logic        r_rd_req;
    logic [31:0] r_rd_addr;
    logic [7:0]  r_sd_data;
    logic [7:0]  r_buf [512];
    logic        w_buf_we;

    // Bytes are only captured while receiving; strays elsewhere are dropped.
    assign w_buf_we = !reset && (r_state == ST_RECV) && io_sd.card_byte_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= 9'd0;
            r_timer      <= 24'd0;
            r_load_valid <= 1'b0;
            r_load_err   <= 1'b0;
            r_rd_req     <= 1'b0;
            r_rd_addr    <= 32'd0;
        end else begin
            r_load_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_sd.sd_load_req) begin
                        r_rd_addr  <= io_sd.sd_sect + SECT_OFFSET;
                        r_load_err <= 1'b0;
                        r_timer    <= 24'd0;
                        r_rd_req   <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (io_sd.card_rd_ack) begin
                        r_rd_req <= 1'b0;
                        r_wr_ptr <= 9'd0;
                        r_timer  <= 24'd0;
                        r_state  <= ST_RECV;
                    end else if (r_timer == TIMER_LAST) begin
                        r_rd_req     <= 1'b0;
                        r_load_err   <= 1'b1;
                        r_load_valid <= 1'b1;
                        r_state      <= ST_ERR;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end
                ST_RECV: begin
                    // A byte arriving on the timeout cycle still counts.
                    if (io_sd.card_byte_valid) begin
                        r_wr_ptr <= r_wr_ptr + 9'd1;
                        r_timer  <= 24'd0;
                        if (r_wr_ptr == 9'd511) begin
                            r_load_valid <= 1'b1;
                            r_state      <= ST_DONE;
                        end
                    end else if (r_timer == TIMER_LAST) begin
                        r_load_err   <= 1'b1;
                        r_load_valid <= 1'b1;
                        r_state      <= ST_ERR;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the buffer array has no reset so it maps onto block RAM; a
    // reset mid-load leaves whatever bytes already arrived.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_wr_ptr] <= io_sd.card_byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sd_data <= 8'd0;
        end else begin
            r_sd_data <= r_buf[io_sd.sd_buf_addr];
        end
    end

    assign io_sd.sd_load_valid = r_load_valid;
    assign io_sd.sd_load_err   = r_load_err;
    assign io_sd.sd_busy       = (r_state != ST_IDLE);
    assign io_sd.sd_data       = r_sd_data;
    assign io_sd.card_rd_req   = r_rd_req;
    assign io_sd.card_rd_addr  = r_rd_addr;

endmodule

// File: tb/tb_sd_sector_loader.sv
// Directed bench for sd_sector_loader: normal loads, gapped streams, timeouts,
// ignored requests/bytes and reset in the middle of a load.
module tb_sd_sector_loader;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sd_sector_loader_if bus ();

    sd_sector_loader #(
        .SECT_OFFSET (32'h800),
        .TIMEOUT     (24'd16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io_sd (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_valid  = 0;
    int         n0;
    logic [7:0] exp_buf [512];

    always @(negedge clk) begin
        if (bus.sd_load_valid === 1'b1) n_valid++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [31:0] sect);
        bus.sd_sect     = sect;
        bus.sd_load_req = 1'b1;
        step();
        bus.sd_load_req = 1'b0;
    endtask

    task automatic ack();
        bus.card_rd_ack = 1'b1;
        step();
        bus.card_rd_ack = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.card_byte_valid = 1'b1;
        bus.card_byte_data  = b;
        step();
        bus.card_byte_valid = 1'b0;
        bus.card_byte_data  = 8'h00;
    endtask

    task automatic readback(input string tag);
        for (int a = 0; a < 512; a++) begin
            bus.sd_buf_addr = a[8:0];
            step();
            check($sformatf("%s[%0d]", tag, a), {24'd0, bus.sd_data}, {24'd0, exp_buf[a]});
        end
    endtask

    initial begin
        reset               = 1'b1;
        bus.sd_sect         = 32'd0;
        bus.sd_load_req     = 1'b0;
        bus.sd_buf_addr     = 9'd0;
        bus.card_rd_ack     = 1'b0;
        bus.card_byte_valid = 1'b0;
        bus.card_byte_data  = 8'h00;
        repeat (3) step();

        check("rst_busy",  {31'd0, bus.sd_busy},       32'd0);
        check("rst_valid", {31'd0, bus.sd_load_valid}, 32'd0);
        check("rst_err",   {31'd0, bus.sd_load_err},   32'd0);
        check("rst_req",   {31'd0, bus.card_rd_req},   32'd0);
        check("rst_addr",  bus.card_rd_addr,           32'd0);
        check("rst_data",  {24'd0, bus.sd_data},       32'd0);
        reset = 1'b0;
        step();

        // T1: offset applied, back-to-back stream of i & 0xFF
        start_load(32'h10);
        check("t1_addr", bus.card_rd_addr,          32'h810);
        check("t1_req",  {31'd0, bus.card_rd_req},  32'd1);
        check("t1_busy", {31'd0, bus.sd_busy},      32'd1);
        repeat (3) step();
        check("t1_req_hold", {31'd0, bus.card_rd_req}, 32'd1);
        ack();
        check("t1_req_drop", {31'd0, bus.card_rd_req}, 32'd0);
        check("t1_busy_recv", {31'd0, bus.sd_busy},    32'd1);
        n0 = n_valid;
        for (int i = 0; i < 512; i++) begin
            exp_buf[i] = i[7:0];
            send_byte(i[7:0]);
            if (i == 510) check("t1_no_early_valid", {31'd0, bus.sd_load_valid}, 32'd0);
        end
        check("t1_valid", {31'd0, bus.sd_load_valid}, 32'd1);
        check("t1_err",   {31'd0, bus.sd_load_err},   32'd0);
        step();
        check("t1_valid_end",   {31'd0, bus.sd_load_valid}, 32'd0);
        check("t1_idle",        {31'd0, bus.sd_busy},       32'd0);
        check("t1_valid_count", n_valid - n0,               32'd1);
        readback("t1_rd");

        // T2: random gaps of 0..5 cycles, never reaching the timeout
        start_load(32'h1234);
        check("t2_addr", bus.card_rd_addr, 32'h1A34);
        ack();
        n0 = n_valid;
        for (int i = 0; i < 512; i++) begin
            repeat ($urandom_range(5, 0)) step();
            exp_buf[i] = 8'($urandom);
            send_byte(exp_buf[i]);
        end
        check("t2_valid", {31'd0, bus.sd_load_valid}, 32'd1);
        check("t2_err",   {31'd0, bus.sd_load_err},   32'd0);
        step();
        check("t2_valid_count", n_valid - n0,         32'd1);
        check("t2_idle",        {31'd0, bus.sd_busy}, 32'd0);
        readback("t2_rd");

        // T3: stream stalls after byte 100 -> error 16 cycles later
        start_load(32'h20);
        ack();
        for (int i = 0; i <= 100; i++) begin
            exp_buf[i] = 8'hA5 ^ i[7:0];
            send_byte(exp_buf[i]);
        end
        repeat (15) step();
        check("t3_pre_valid", {31'd0, bus.sd_load_valid}, 32'd0);
        check("t3_pre_busy",  {31'd0, bus.sd_busy},       32'd1);
        step();
        check("t3_valid", {31'd0, bus.sd_load_valid}, 32'd1);
        check("t3_err",   {31'd0, bus.sd_load_err},   32'd1);
        step();
        check("t3_valid_end", {31'd0, bus.sd_load_valid}, 32'd0);
        check("t3_err_held",  {31'd0, bus.sd_load_err},   32'd1);
        check("t3_idle",      {31'd0, bus.sd_busy},       32'd0);
        readback("t3_rd");
        start_load(32'h30);
        check("t3_err_clear", {31'd0, bus.sd_load_err}, 32'd0);
        check("t3_new_addr",  bus.card_rd_addr,         32'h830);

        // T4: request during RECV ignored; bytes and ack in IDLE dropped
        ack();
        n0 = n_valid;
        for (int i = 0; i < 512; i++) begin
            if (i == 50) begin
                bus.sd_sect     = 32'h999;
                bus.sd_load_req = 1'b1;
                step();
                bus.sd_load_req = 1'b0;
                check("t4_no_req",  {31'd0, bus.card_rd_req}, 32'd0);
                check("t4_addr_kept", bus.card_rd_addr,       32'h830);
            end
            exp_buf[i] = 8'(i * 3);
            send_byte(exp_buf[i]);
        end
        check("t4_valid", {31'd0, bus.sd_load_valid}, 32'd1);
        step();
        check("t4_valid_count", n_valid - n0,         32'd1);
        check("t4_idle",        {31'd0, bus.sd_busy}, 32'd0);
        bus.card_byte_valid = 1'b1;
        bus.card_byte_data  = 8'hEE;
        bus.card_rd_ack     = 1'b1;
        repeat (5) step();
        bus.card_byte_valid = 1'b0;
        bus.card_rd_ack     = 1'b0;
        check("t4_idle_stray", {31'd0, bus.sd_busy},     32'd0);
        check("t4_req_stray",  {31'd0, bus.card_rd_req}, 32'd0);
        readback("t4_rd");

        // T5: reset after byte 200, then a normal full load
        start_load(32'h40);
        ack();
        for (int i = 0; i <= 200; i++) begin
            exp_buf[i] = 8'h5A + i[7:0];
            send_byte(exp_buf[i]);
        end
        n0    = n_valid;
        reset = 1'b1;
        step();
        check("t5_idle",  {31'd0, bus.sd_busy},       32'd0);
        check("t5_req",   {31'd0, bus.card_rd_req},   32'd0);
        check("t5_valid", {31'd0, bus.sd_load_valid}, 32'd0);
        reset = 1'b0;
        step();
        check("t5_no_pulse", n_valid - n0, 32'd0);
        readback("t5_partial");
        start_load(32'h41);
        check("t5_addr", bus.card_rd_addr, 32'h841);
        ack();
        n0 = n_valid;
        for (int i = 0; i < 512; i++) begin
            exp_buf[i] = ~i[7:0];
            send_byte(exp_buf[i]);
        end
        check("t5_full_valid", {31'd0, bus.sd_load_valid}, 32'd1);
        check("t5_full_err",   {31'd0, bus.sd_load_err},   32'd0);
        step();
        check("t5_full_count", n_valid - n0, 32'd1);
        readback("t5_rd");

        // T6: request never acknowledged
        start_load(32'h50);
        repeat (15) step();
        check("t6_req_hold", {31'd0, bus.card_rd_req},   32'd1);
        check("t6_no_valid", {31'd0, bus.sd_load_valid}, 32'd0);
        step();
        check("t6_valid", {31'd0, bus.sd_load_valid}, 32'd1);
        check("t6_err",   {31'd0, bus.sd_load_err},   32'd1);
        check("t6_req",   {31'd0, bus.card_rd_req},   32'd0);
        step();
        check("t6_idle",     {31'd0, bus.sd_busy},     32'd0);
        check("t6_err_held", {31'd0, bus.sd_load_err}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
